// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the 1R1W masked SRAM.
// Optional feature macro: SRAM_PARITY_EN (per-segment even parity).
package sram_pkg;

  typedef enum logic {INIT = 1'b0, READY = 1'b1} init_state_e;

  // Bits covered by one write-mask segment.
  function automatic int seg_width(input int data_w, input int mask_w);
    return data_w / mask_w;
  endfunction

  // One parity bit per segment.
  function automatic int par_width(input int mask_w);
    return mask_w;
  endfunction

  // Legal shape: whole segments, and the address bus reaches every entry.
  function automatic bit cfg_ok(input int depth, input int addr_w,
                                input int data_w, input int mask_w);
    return (depth > 0) && (mask_w > 0) && (data_w % mask_w == 0) &&
           ((64'd1 << addr_w) >= 64'(depth));
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Post-reset zeroing sweep: walks every entry once, then holds READY until reset.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ready,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  init_state_e state;

  // Sweep FSM; ready and init_we are registered complements of each other.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      init_addr <= '0;
      init_we   <= 1'b1;
      ready     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (init_addr == LAST) begin
            state   <= READY;
            init_we <= 1'b0;
            ready   <= 1'b1;
          end else begin
            init_addr <= init_addr + ADDR_W'(1);
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: rtl/sram_1r1w_masked.sv
// One write port + one read port SRAM model with per-segment write mask,
// zeroing sweep after reset, write-first read and a held read output.
// Optional feature macro: SRAM_PARITY_EN adds per-segment even parity and r_err.
module sram_1r1w_masked
  import sram_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 96,
  parameter int MASK_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_data_valid,
  output logic              ready,
  output logic              r_err
);

  localparam int SEG_W = seg_width(DATA_W, MASK_W);
  localparam int PAR_W = par_width(MASK_W);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (!cfg_ok(DEPTH, ADDR_W, DATA_W, MASK_W)) begin : g_cfg_err
    $error("sram_1r1w_masked: illegal DEPTH/ADDR_W/DATA_W/MASK_W combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef SRAM_PARITY_EN
  logic [PAR_W-1:0]  par [DEPTH];
`endif

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;

  sram_init_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_init (
    .clock     (clock),
    .reset     (reset),
    .ready     (ready),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  logic [ADDR_W-1:0] wa;
  logic [MASK_W-1:0] wm;
  logic [DATA_W-1:0] wd;

  // Write path mux: sweep owns the port until ready; out-of-range writes drop.
  always_comb begin
    wa = w_addr;
    wm = '0;
    wd = w_data;
    if (init_we) begin
      wa = init_addr;
      wm = '1;
      wd = '0;
    end else if (w_valid && ready && ({1'b0, w_addr} < DEPTH_L)) begin
      wm = w_mask;
    end
  end

  // Array update, one segment per mask bit (parity tracks the segment).
  always_ff @(posedge clock) begin
    for (int i = 0; i < MASK_W; i++) begin
      if (wm[i]) begin
        mem[wa][i*SEG_W +: SEG_W] <= wd[i*SEG_W +: SEG_W];
`ifdef SRAM_PARITY_EN
        par[wa][i] <= ^wd[i*SEG_W +: SEG_W];
`endif
      end
    end
  end

  // Read is captured at the request edge and the array is sampled one edge
  // later, so a write landing at the request edge is already visible
  // (write-first) without a separate bypass mux.
  logic [1:0]        vld_pipe;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_word;
  logic [PAR_W-1:0]  par_bad;

  // Array output for the captured address; zero for addresses past DEPTH.
  always_comb begin
    rd_word = '0;
    par_bad = '0;
    if ({1'b0, rd_addr_q} < DEPTH_L) begin
      rd_word = mem[rd_addr_q];
`ifdef SRAM_PARITY_EN
      for (int i = 0; i < MASK_W; i++)
        par_bad[i] = (^rd_word[i*SEG_W +: SEG_W]) != par[rd_addr_q][i];
`endif
    end
  end

  // Read pipeline; r_data only moves when a read completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      rd_addr_q <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
    end else begin
      vld_pipe[0] <= r_valid && ready;
      vld_pipe[1] <= vld_pipe[0];
      if (r_valid && ready) rd_addr_q <= r_addr;
      if (vld_pipe[0]) r_data <= rd_word;
      r_err <= vld_pipe[0] && (|par_bad);
    end
  end

  assign r_data_valid = vld_pipe[1];

endmodule
